serial_subtractor_module: RTL and testbench

//  Bit-serial, LSB-first unsigned subtractor: computes a - b over WIDTH cycles with one
//  1-bit full-subtractor cell and a registered borrow. It is the inverse-direction companion
//  of the arithmetic block's adders, for area-constrained datapaths that can accept latency.
//  A start/busy/done handshake sits between it and the controlling FSM.

---
 rtl/serial_subtractor_module_pkg.sv | 17 +
 rtl/serial_subtractor_module_full_subtractor.sv | 23 ++
 rtl/serial_subtractor_module.sv | 93 +++++++++
 tb/tb_serial_subtractor_module.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_module_pkg.sv
// Shared arith definitions: FSM encoding, default width, counter sizing.
// Imported by the serial subtractor top and its cell.
package serial_subtractor_module_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_module_full_subtractor.sv
// 1-bit full subtractor cell built from xnor/not/and/or gates.
// diff = a ^ b ^ bin, bout = (~a & b) | (~(a ^ b) & bin).
module full_subtractor_gatelevel_module (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic eq_ab;
    logic n_a;
    logic t_ab;
    logic t_eq;

    xnor g_eq   (eq_ab, a, b);
    xnor g_diff (diff, eq_ab, bin);
    not  g_na   (n_a, a);
    and  g_t0   (t_ab, n_a, b);
    and  g_t1   (t_eq, eq_ab, bin);
    or   g_bo   (bout, t_ab, t_eq);

endmodule

// File: rtl/serial_subtractor_module.sv
// Bit-serial LSB-first unsigned subtractor with start/busy/done handshake.
// One subtractor cell, registered borrow, result visible only on done.
module serial_subtractor_module
    import serial_subtractor_module_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             d_i;
    logic             b_next;
    logic [WIDTH-1:0] res_next;

    full_subtractor_gatelevel_module u_fs (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .bin  (brw),
        .diff (d_i),
        .bout (b_next)
    );

    assign res_next = {d_i, res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sh_a       <= '0;
            sh_b       <= '0;
            res        <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        res   <= '0;
                        brw   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res  <= res_next;
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                    brw  <= b_next;
                    cnt  <= cnt + 1'b1;
                    // last bit: publish the full word and final borrow together
                    if (cnt == CW'(WIDTH - 1)) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        diff       <= res_next;
                        borrow_out <= b_next;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_module.sv
// Directed and randomised checks for serial_subtractor_module (WIDTH=8).
module tb_serial_subtractor_module;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_module #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE, follow it until busy drops (bounded).
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         output int lat, output logic [7:0] dv,
                         output logic bo, output int busy_cnt,
                         output int done_cnt);
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        dv = 8'h00;
        bo = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                lat = k;
                dv = diff;
                bo = borrow_out;
            end
            if (!busy) break;
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        tick();
        tick();
        checks++;
        if ({busy, done, diff, borrow_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b diff=%h bo=%b, want all 0",
                     busy, done, diff, borrow_out);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_nominal();
        int lat, bc, dc;
        logic [7:0] dv;
        logic bo;
        do_op(8'h5A, 8'h23, lat, dv, bo, bc, dc);
        checks++;
        if (dc !== 1 || lat !== 8) begin
            errors++;
            $display("FAIL nominal_latency: done_cnt=%0d lat=%0d, want 1 and 8", dc, lat);
        end
        checks++;
        if (bc !== 9) begin
            errors++;
            $display("FAIL nominal_busy: busy cycles=%0d, want 9", bc);
        end
        checks++;
        if ({bo, dv} !== {1'b0, 8'h37}) begin
            errors++;
            $display("FAIL nominal_result: diff=%h bo=%b, want 37 0", dv, bo);
        end
    endtask

    task automatic test_underflow();
        int lat, bc, dc;
        logic [7:0] dv;
        logic bo;
        do_op(8'h00, 8'h01, lat, dv, bo, bc, dc);
        checks++;
        if ({bo, dv} !== {1'b1, 8'hFF} || lat !== 8) begin
            errors++;
            $display("FAIL underflow: diff=%h bo=%b lat=%0d, want ff 1 8", dv, bo, lat);
        end
        do_op(8'h80, 8'h80, lat, dv, bo, bc, dc);
        checks++;
        if ({bo, dv} !== {1'b0, 8'h00} || lat !== 8) begin
            errors++;
            $display("FAIL equal: diff=%h bo=%b lat=%0d, want 00 0 8", dv, bo, lat);
        end
        do_op(8'hA5, 8'h00, lat, dv, bo, bc, dc);
        checks++;
        if ({bo, dv} !== {1'b0, 8'hA5} || lat !== 8) begin
            errors++;
            $display("FAIL b_zero: diff=%h bo=%b lat=%0d, want a5 0 8", dv, bo, lat);
        end
    endtask

    task automatic test_busy_guard();
        int n_done;
        int t0, t1;
        logic [7:0] d0, d1;
        logic b0, b1;
        n_done = 0;
        t0 = -1;
        t1 = -1;
        d0 = 8'h00;
        d1 = 8'h00;
        b0 = 1'b0;
        b1 = 1'b0;
        a = 8'h5A;
        b = 8'h23;
        start = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) begin
            if (k == 3) begin
                a = 8'h11;
                b = 8'h22;
            end
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    t0 = k; d0 = diff; b0 = borrow_out;
                end else begin
                    t1 = k; d1 = diff; b1 = borrow_out;
                end
            end
            if (k == 19) start = 1'b0;
            tick();
        end
        for (int k = 0; k < 20 && busy; k++) tick();
        checks++;
        if (n_done !== 2 || t0 !== 8 || t1 !== 18) begin
            errors++;
            $display("FAIL busy_guard_count: dones=%0d at %0d,%0d, want 2 at 8,18",
                     n_done, t0, t1);
        end
        checks++;
        if ({b0, d0} !== {1'b0, 8'h37}) begin
            errors++;
            $display("FAIL busy_guard_first: diff=%h bo=%b, want 37 0", d0, b0);
        end
        checks++;
        if ({b1, d1} !== {1'b1, 8'hEF}) begin
            errors++;
            $display("FAIL busy_guard_second: diff=%h bo=%b, want ef 1", d1, b1);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, dc;
        int held_bad;
        int lat2;
        logic [7:0] dv;
        logic bo;
        do_op(8'h5A, 8'h23, lat, dv, bo, bc, dc);
        a = 8'hFF;
        b = 8'h0F;
        start = 1'b1;
        tick();
        start = 1'b0;
        held_bad = 0;
        lat2 = -1;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                lat2 = k;
                break;
            end
            if (diff !== 8'h37 || borrow_out !== 1'b0) held_bad++;
            tick();
        end
        checks++;
        if (held_bad !== 0) begin
            errors++;
            $display("FAIL b2b_hold: %0d cycles diff changed early, want 0", held_bad);
        end
        checks++;
        if (lat2 !== 8 || diff !== 8'hF0 || borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: lat=%0d diff=%h bo=%b, want 8 f0 0",
                     lat2, diff, borrow_out);
        end
        for (int k = 0; k < 5 && busy; k++) tick();
    endtask

    task automatic test_reset_mid_op();
        int lat, bc, dc;
        int seen_done;
        logic [7:0] dv;
        logic bo;
        a = 8'h5A;
        b = 8'h23;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 4; k++) begin
            if (done) seen_done++;
            tick();
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, diff, borrow_out} !== 11'd0) begin
            errors++;
            $display("FAIL midrst_outputs: busy=%b done=%b diff=%h bo=%b, want all 0",
                     busy, done, diff, borrow_out);
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) seen_done++;
            tick();
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL midrst_no_done: activity=%0d cycles, want 0", seen_done);
        end
        do_op(8'h10, 8'h20, lat, dv, bo, bc, dc);
        checks++;
        if ({bo, dv} !== {1'b1, 8'hF0} || lat !== 8) begin
            errors++;
            $display("FAIL midrst_next_op: diff=%h bo=%b lat=%0d, want f0 1 8",
                     dv, bo, lat);
        end
    endtask

    task automatic test_random();
        int lat, bc, dc;
        logic [7:0] dv;
        logic bo;
        logic [7:0] ra, rb;
        logic [8:0] exp;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            exp = {1'b0, ra} - {1'b0, rb};
            do_op(ra, rb, lat, dv, bo, bc, dc);
            checks++;
            if ({bo, dv} !== exp || lat !== 8 || dc !== 1) begin
                errors++;
                $display("FAIL random_%0d: %h-%h got diff=%h bo=%b lat=%0d, want %h %b 8",
                         i, ra, rb, dv, bo, lat, exp[7:0], exp[8]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_underflow();
        test_busy_guard();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
